// File: rtl/ddfs_sweep_ctrl.sv
// Frequency-sweep sequencer for the ddfs tuning word: steps FTW from start to stop
// with a programmable dwell, in single, sawtooth-repeat or triangle mode.
module ddfs_sweep_ctrl #(
  parameter int FTW_W   = 16,
  parameter int DWELL_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [FTW_W-1:0]   cfg_start_ftw,
  input  logic [FTW_W-1:0]   cfg_stop_ftw,
  input  logic [FTW_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  output logic [FTW_W-1:0]   q_ftw,
  output logic               ftw_update,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   sweep_count,
  output logic [1:0]         dbg_state
);

  // Control semantics: start is a level sampled only in IDLE on a rising clk edge;
  // abort is sampled every edge and overrides everything, including start.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_dir;
  logic [DWELL_W-1:0]   r_cnt;
  logic [FTW_W-1:0]     r_start;
  logic [FTW_W-1:0]     r_stop;
  logic [FTW_W-1:0]     r_step;
  logic [DWELL_W-1:0]   r_dwell;
  logic [1:0]           r_mode;
  logic [FTW_W-1:0]     r_ftw;
  logic                 r_upd;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [CNT_W-1:0]     r_sweep_cnt;

  logic                 w_cfg_ok;
  logic                 w_expire;
  logic                 w_at_top;
  logic                 w_at_bot;
  logic                 w_single;
  logic                 w_tri;
  logic                 w_single_end;
  logic [FTW_W:0]       w_up_sum;
  logic [FTW_W:0]       w_dn_diff;
  logic [FTW_W-1:0]     w_up_nxt;
  logic [FTW_W-1:0]     w_dn_nxt;

  logic                 w_load_cfg;
  logic                 w_dir_nxt;
  logic [DWELL_W-1:0]   w_cnt_nxt;
  logic [FTW_W-1:0]     w_ftw_nxt;
  logic                 w_upd_nxt;
  logic                 w_done_nxt;
  logic                 w_err_nxt;
  logic [CNT_W-1:0]     w_sweep_nxt;

  assign w_cfg_ok     = (cfg_step != '0) && (cfg_start_ftw <= cfg_stop_ftw);
  // The NEXT decision lives entirely in this cycle: it is the DWELL cycle whose counter is 0.
  assign w_expire     = (r_state == S_DWELL) && (r_cnt == '0);
  assign w_at_top     = (r_ftw == r_stop);
  assign w_at_bot     = (r_ftw == r_start);
  assign w_single     = (r_mode == 2'b00) || (r_mode == 2'b11);
  assign w_tri        = (r_mode == 2'b10) && (r_start != r_stop);
  assign w_single_end = !r_dir && w_at_top && w_single;

  // One extra bit so a carry or borrow clamps instead of wrapping.
  assign w_up_sum  = {1'b0, r_ftw} + {1'b0, r_step};
  assign w_dn_diff = {1'b0, r_ftw} - {1'b0, r_step};
  assign w_up_nxt  = (w_up_sum > {1'b0, r_stop}) ? r_stop : w_up_sum[FTW_W-1:0];
  assign w_dn_nxt  = (w_dn_diff[FTW_W] || (w_dn_diff[FTW_W-1:0] < r_start)) ?
                     r_start : w_dn_diff[FTW_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_cnt       <= '0;
      r_start     <= '0;
      r_stop      <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
      r_mode      <= 2'b00;
      r_ftw       <= '0;
      r_upd       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_sweep_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ftw       <= w_ftw_nxt;
      r_upd       <= w_upd_nxt;
      r_busy      <= (w_state_nxt == S_DWELL);
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_sweep_cnt <= w_sweep_nxt;
      if (w_load_cfg) begin
        r_start <= cfg_start_ftw;
        r_stop  <= cfg_stop_ftw;
        r_step  <= cfg_step;
        r_dwell <= cfg_dwell;
        r_mode  <= cfg_mode;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start && w_cfg_ok) w_state_nxt = S_DWELL;
        S_DWELL: if (w_expire && w_single_end) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_load_cfg  = 1'b0;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_ftw_nxt   = r_ftw;
    w_upd_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_sweep_nxt = r_sweep_cnt;
    if (!abort) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              w_load_cfg = 1'b1;
              w_ftw_nxt  = cfg_start_ftw;
              w_upd_nxt  = 1'b1;
              w_cnt_nxt  = cfg_dwell;
              w_dir_nxt  = 1'b0;
            end else begin
              w_err_nxt  = 1'b1;
            end
          end
        end
        S_DWELL: begin
          if (!w_expire) begin
            w_cnt_nxt = r_cnt - DWELL_W'(1);
          end else begin
            w_cnt_nxt = r_dwell;
            w_upd_nxt = 1'b1;
            if (!r_dir) begin
              if (!w_at_top) begin
                w_ftw_nxt = w_up_nxt;
              end else if (w_single) begin
                w_upd_nxt   = 1'b0;
                w_done_nxt  = 1'b1;
                w_sweep_nxt = r_sweep_cnt + CNT_W'(1);
              end else if (w_tri) begin
                w_dir_nxt = 1'b1;
                w_ftw_nxt = w_dn_nxt;
              end else begin
                w_ftw_nxt   = r_start;
                w_sweep_nxt = r_sweep_cnt + CNT_W'(1);
              end
            end else begin
              // Bottom of a triangle: start is not re-emitted, go straight up.
              if (w_at_bot) begin
                w_dir_nxt   = 1'b0;
                w_ftw_nxt   = w_up_nxt;
                w_sweep_nxt = r_sweep_cnt + CNT_W'(1);
              end else begin
                w_ftw_nxt = w_dn_nxt;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign q_ftw       = r_ftw;
  assign ftw_update  = r_upd;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign sweep_count = r_sweep_cnt;
  assign dbg_state   = r_state;

endmodule
